// File: rtl/axi_dc_src_channel.sv
// -----------------------------------------------------------------------------
// axi_dc_src_channel
//
// Writer half of one token-based dual-clock AXI channel. Upstream beats are
// stored in a BUFFER_WIDTH-entry register file. Progress is published to the
// reader domain as a Johnson-coded write token. The reader's Johnson-coded
// read pointer comes back and passes through a 2-flop synchronizer, which is
// used to detect full. The entry the reader points at is exposed
// combinationally on data_async_o, and only the reader domain samples it.
//
// Ports
//   clk_i          in   source clock
//   rst_i          in   asynchronous, active-high reset
//   valid_i        in   upstream beat valid
//   data_i         in   upstream beat payload [DATA_WIDTH]
//   ready_o        out  upstream ready (registered-only path, never from valid_i)
//   writetoken_o   out  Johnson write count [BUFFER_WIDTH]
//   readpointer_i  in   Johnson read count from reader domain (async)
//   data_async_o   out  buffer entry selected by raw readpointer_i
//
// Handshake: a beat transfers on a rising clk_i edge where valid_i and
// ready_o are both high. valid_i may drop without a transfer. ready_o
// depends only on flops (token and synchronized pointer).
// -----------------------------------------------------------------------------
module axi_dc_src_channel #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    ready_o,
  output logic [BUFFER_WIDTH-1:0] writetoken_o,
  input  logic [BUFFER_WIDTH-1:0] readpointer_i,
  output logic [DATA_WIDTH-1:0]   data_async_o
);

  localparam int IDX_W = $clog2(BUFFER_WIDTH);

  // Map a Johnson code to its slot. While the MSB is clear the count equals
  // the number of ones. Once the MSB is set, the ones drain from the bottom,
  // so the count is W + (W - ones). Taken mod W, that is (W - ones) mod W.
  function automatic logic [IDX_W-1:0] johnson_idx(input logic [BUFFER_WIDTH-1:0] t);
    logic [IDX_W:0] pc;
    logic [IDX_W:0] cnt;
    pc = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      pc = pc + {{IDX_W{1'b0}}, t[i]};
    end
    cnt = t[BUFFER_WIDTH-1] ? ((IDX_W+1)'(BUFFER_WIDTH) - pc) : pc;
    return cnt[IDX_W-1:0];
  endfunction

  logic [BUFFER_WIDTH-1:0] r_wtoken;
  logic [BUFFER_WIDTH-1:0] r_rp_s1;
  logic [BUFFER_WIDTH-1:0] r_rp_s2;
  logic [DATA_WIDTH-1:0]   r_buf [BUFFER_WIDTH];

  logic                    w_full;
  logic                    w_push;
  logic [IDX_W-1:0]        w_widx;
  logic [IDX_W-1:0]        w_ridx;
  logic [BUFFER_WIDTH-1:0] w_wtoken_next;

  // The writer leads the reader by exactly W Johnson states when the two
  // codes are bitwise complements. That condition means all W slots hold
  // data. No slot is held in reserve.
  assign w_full        = (r_wtoken == ~r_rp_s2);
  assign ready_o       = ~w_full;
  assign w_push        = valid_i & ~w_full;
  assign w_widx        = johnson_idx(r_wtoken);
  assign w_ridx        = johnson_idx(readpointer_i);
  assign w_wtoken_next = {r_wtoken[BUFFER_WIDTH-2:0], ~r_wtoken[BUFFER_WIDTH-1]};

  // The raw asynchronous pointer selects this entry. The reader guarantees
  // the slot is stable, because the writer cannot reuse it until the reader
  // has moved past it.
  assign data_async_o  = r_buf[w_ridx];
  assign writetoken_o  = r_wtoken;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wtoken <= '0;
      r_rp_s1  <= '0;
      r_rp_s2  <= '0;
    end else begin
      r_rp_s1 <= readpointer_i;
      r_rp_s2 <= r_rp_s1;
      if (w_push) begin
        r_wtoken <= w_wtoken_next;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUFFER_WIDTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_push) begin
      r_buf[w_widx] <= data_i;
    end
  end

endmodule

// File: tb/tb_axi_dc_src_channel.sv
// -----------------------------------------------------------------------------
// tb_axi_dc_src_channel
//
// Directed bench for the writer half of the dual-clock channel. Inputs are
// driven and outputs are sampled on the falling edge of clk. The reader
// domain is modelled by stepping readpointer_i through the Johnson sequence.
// -----------------------------------------------------------------------------
module tb_axi_dc_src_channel;

  localparam int DW = 32;
  localparam int BW = 8;

  // Johnson sequence for W=8, indexed by count mod 16
  localparam logic [BW-1:0] TOK [16] = '{
    8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
    8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o;
  logic [BW-1:0] writetoken_o;
  logic [BW-1:0] readpointer_i = '0;
  logic [DW-1:0] data_async_o;

  axi_dc_src_channel #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .ready_o       (ready_o),
    .writetoken_o  (writetoken_o),
    .readpointer_i (readpointer_i),
    .data_async_o  (data_async_o)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int wc = 0;   // writes issued since last reset
  int rc = 0;   // reader advances since last reset

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Synchronized pointer must only ever move by one Johnson step
  logic [BW-1:0] rp_prev;
  always @(negedge clk or posedge rst) begin
    if (rst) rp_prev <= '0;
    else begin
      assert ($countones(dut.r_rp_s2 ^ rp_prev) <= 1)
        else $error("FAIL sync_step: %h -> %h", rp_prev, dut.r_rp_s2);
      rp_prev <= dut.r_rp_s2;
    end
  end

  // ---------------- driver tasks ----------------
  // One beat presented for one edge; caller guarantees ready_o is high
  task automatic push_beat(input logic [DW-1:0] d);
    valid_i = 1'b1;
    data_i  = d;
    @(negedge clk);
    valid_i = 1'b0;
    exp_q.push_back(d);
    wc++;
    check_eq("token_step", {24'h0, writetoken_o}, {24'h0, TOK[wc % 16]});
  endtask

  // Reader consumes the entry it points at, then steps its pointer
  task automatic advance_reader();
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check_eq("reader_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("read_data", data_async_o, e);
    end
    rc++;
    readpointer_i = TOK[rc % 16];
  endtask

  task automatic pulse_reset();
    #1;
    rst = 1'b1;
    readpointer_i = '0;
    #1;
    rst = 1'b0;
    wc = 0;
    rc = 0;
    exp_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset with no clock running
    #1 rst = 1'b1;
    #1;
    check_eq("rst_token", {24'h0, writetoken_o}, 32'h0);
    check_eq("rst_ready", {31'h0, ready_o}, 32'h1);
    check_eq("rst_data",  data_async_o, 32'h0);
    #1 rst = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);

    // Fill: eight back-to-back beats
    for (int i = 0; i < 8; i++) begin
      push_beat(32'hA0 + i);
      check_eq("fill_ready", {31'h0, ready_o}, (i < 7) ? 32'h1 : 32'h0);
    end

    // Held valid while full is not accepted
    valid_i = 1'b1;
    data_i  = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("held_token", {24'h0, writetoken_o}, 32'hFF);
      check_eq("held_ready", {31'h0, ready_o}, 32'h0);
    end
    valid_i = 1'b0;

    // Drain one: data switches immediately, ready follows two edges later
    advance_reader();
    #1;
    check_eq("drain_data_after", data_async_o, 32'hA1);
    @(negedge clk);
    check_eq("drain_ready_e1", {31'h0, ready_o}, 32'h0);
    @(negedge clk);
    check_eq("drain_ready_e2", {31'h0, ready_o}, 32'h1);

    // Wrap: 16 writes interleaved with reader advances
    for (int i = 0; i < 16; i++) begin
      push_beat(32'hB0 + i);
      check_eq("wrap_full", {31'h0, ready_o}, 32'h0);
      advance_reader();
      repeat (2) @(negedge clk);
      check_eq("wrap_ready", {31'h0, ready_o}, 32'h1);
    end
    check_eq("wrap_token_end", {24'h0, writetoken_o}, 32'hFF);

    // Drain everything that is left
    for (int i = 0; i < 7; i++) begin
      advance_reader();
      repeat (2) @(negedge clk);
    end
    check_eq("drained_q", exp_q.size(), 32'd0);
    check_eq("drained_ready", {31'h0, ready_o}, 32'h1);

    // Simultaneous: full, pointer advance and held valid together
    for (int i = 0; i < 8; i++) push_beat(32'hC0 + i);
    check_eq("sim_full", {31'h0, ready_o}, 32'h0);
    valid_i = 1'b1;
    data_i  = 32'hD0;
    advance_reader();
    #1;
    check_eq("sim_data_next", data_async_o, 32'hC1);
    @(negedge clk);
    check_eq("sim_e1_token", {24'h0, writetoken_o}, 32'h00);
    check_eq("sim_e1_ready", {31'h0, ready_o}, 32'h0);
    @(negedge clk);
    check_eq("sim_e2_token", {24'h0, writetoken_o}, 32'h00);
    check_eq("sim_e2_ready", {31'h0, ready_o}, 32'h1);
    @(negedge clk);
    check_eq("sim_e3_token", {24'h0, writetoken_o}, 32'h01);
    check_eq("sim_e3_ready", {31'h0, ready_o}, 32'h0);
    valid_i = 1'b0;
    @(negedge clk);
    check_eq("sim_e4_token", {24'h0, writetoken_o}, 32'h01);

    // Mid-operation reset
    pulse_reset();
    @(negedge clk);
    push_beat(32'hE0);
    push_beat(32'hE1);
    push_beat(32'hE2);
    check_eq("mid_pre_data", data_async_o, 32'hE0);
    pulse_reset();
    check_eq("mid_token", {24'h0, writetoken_o}, 32'h0);
    check_eq("mid_ready", {31'h0, ready_o}, 32'h1);
    check_eq("mid_slot0", data_async_o, 32'h0);
    @(negedge clk);
    push_beat(32'hF0);
    check_eq("mid_write_slot0", data_async_o, 32'hF0);
    readpointer_i = 8'h01;
    #1;
    check_eq("mid_slot1_clear", data_async_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
